stfq_ranker: RTL and testbench

Enqueue-side rank generator that feeds the PIFO push port. It accepts packets over a valid/ready handshake and computes a Start-Time Fair Queueing rank per packet: `start = max(V, F[flow])` and `F[flow] = start + len*weight[flow]`. It then drives `push`/`push_rank`/`push_value`/`push_flow` into the PIFO. Departure notifications from the dequeue side advance virtual time `V` and release per-flow occupancy.

---
 rtl/stfq_ranker.sv | 158 +++++++++++++++
 tb/tb_stfq_ranker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stfq_ranker.sv
// stfq_ranker: Start-Time Fair Queueing rank generator that feeds a PIFO push port.
// Define STFQ_WEIGHT_EN to build per-flow weights and the len*weight multiply.
module stfq_ranker #(
  parameter int FLOWS     = 10,
  parameter int BANK_SIZE = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  input  logic [FLOWS-1:0] in_flow,
  input  logic [15:0]      in_len,
  output logic             push,
  output logic [31:0]      push_rank,
  output logic [31:0]      push_value,
  output logic [FLOWS-1:0] push_flow,
  input  logic             deq_valid,
  input  logic [31:0]      deq_rank,
  input  logic [FLOWS-1:0] deq_flow,
  input  logic             cfg_we,
  input  logic [FLOWS-1:0] cfg_flow,
  input  logic [7:0]       cfg_weight
);
  localparam int CW = $clog2(BANK_SIZE + 1);
  localparam int IW = (FLOWS > 1) ? $clog2(FLOWS) : 1;

  function automatic logic is_onehot(input logic [FLOWS-1:0] v);
    return (v != '0) && ((v & (v - FLOWS'(1))) == '0);
  endfunction

  function automatic logic [IW-1:0] to_idx(input logic [FLOWS-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < FLOWS; i++) begin
      idx = v[i] ? IW'(i) : idx;
    end
    return idx;
  endfunction

  logic [CW-1:0]    r_count [FLOWS];
  logic [31:0]      r_fin   [FLOWS];
  logic [31:0]      r_vtime;
  logic             r_s1_valid;
  logic [31:0]      r_s1_value;
  logic [FLOWS-1:0] r_s1_flow;
  logic [15:0]      r_s1_len;
  logic             r_push;
  logic [31:0]      r_push_rank;
  logic [31:0]      r_push_value;
  logic [FLOWS-1:0] r_push_flow;

  logic [IW-1:0]    w_in_idx;
  logic [IW-1:0]    w_s1_idx;
  logic             w_accept;
  logic [FLOWS-1:0] w_inc;
  logic [FLOWS-1:0] w_dec;
  logic [31:0]      w_start;
  logic [23:0]      w_prod;
  logic [32:0]      w_sum;
  logic [31:0]      w_fin;

  assign w_in_idx = to_idx(in_flow);
  assign in_ready = rst && is_onehot(in_flow) && (r_count[w_in_idx] < CW'(BANK_SIZE));
  assign w_accept = in_valid && in_ready;
  assign w_inc    = w_accept  ? in_flow  : '0;
  assign w_dec    = deq_valid ? deq_flow : '0;

`ifdef STFQ_WEIGHT_EN
  logic [7:0] r_weight [FLOWS];

  // Per-flow weight table; a written 0 is stored as 1 so every packet still advances F.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLOWS; i++) r_weight[i] <= 8'd1;
    end else if (cfg_we && is_onehot(cfg_flow)) begin
      r_weight[to_idx(cfg_flow)] <= (cfg_weight == 8'd0) ? 8'd1 : cfg_weight;
    end
  end

  assign w_prod = 24'(r_s1_len) * 24'(r_weight[w_s1_idx]);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{cfg_we, cfg_flow, cfg_weight};
  assign w_prod       = {8'd0, r_s1_len};
`endif

  // Tag evaluation for the packet held in S1; the finish tag saturates instead of wrapping.
  assign w_s1_idx = to_idx(r_s1_flow);
  assign w_start  = (r_vtime > r_fin[w_s1_idx]) ? r_vtime : r_fin[w_s1_idx];
  assign w_sum    = {1'b0, w_start} + {9'd0, w_prod};
  assign w_fin    = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];

  // S1 capture and registered PIFO push outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_value   <= 32'd0;
      r_s1_flow    <= '0;
      r_s1_len     <= 16'd0;
      r_push       <= 1'b0;
      r_push_rank  <= 32'd0;
      r_push_value <= 32'd0;
      r_push_flow  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_value <= in_value;
        r_s1_flow  <= in_flow;
        r_s1_len   <= in_len;
      end
      r_push <= r_s1_valid;
      if (r_s1_valid) begin
        r_push_rank  <= w_start;
        r_push_value <= r_s1_value;
        r_push_flow  <= r_s1_flow;
      end
    end
  end

  // Per-flow finish tags, written one edge after the S1 read so the next packet sees them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLOWS; i++) r_fin[i] <= 32'd0;
    end else if (r_s1_valid) begin
      r_fin[w_s1_idx] <= w_fin;
    end
  end

  // Occupancy: simultaneous accept and departure cancel; departures from an empty flow are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLOWS; i++) r_count[i] <= '0;
    end else begin
      for (int i = 0; i < FLOWS; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_count[i] <= r_count[i] + CW'(1);
        end else if (!w_inc[i] && w_dec[i] && (r_count[i] != '0)) begin
          r_count[i] <= r_count[i] - CW'(1);
        end
      end
    end
  end

  // Virtual time only moves forward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vtime <= 32'd0;
    end else if (deq_valid && (deq_rank > r_vtime)) begin
      r_vtime <= deq_rank;
    end
  end

  assign push       = r_push;
  assign push_rank  = r_push_rank;
  assign push_value = r_push_value;
  assign push_flow  = r_push_flow;
endmodule

// File: tb/tb_stfq_ranker.sv
// Self-checking bench for stfq_ranker: directed steps, reference tag model, push scoreboard.
module tb_stfq_ranker;
  localparam int NF = 10;
  localparam int BS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_value;
  logic [NF-1:0] in_flow;
  logic [15:0]   in_len;
  logic          push;
  logic [31:0]   push_rank;
  logic [31:0]   push_value;
  logic [NF-1:0] push_flow;
  logic          deq_valid;
  logic [31:0]   deq_rank;
  logic [NF-1:0] deq_flow;
  logic          cfg_we;
  logic [NF-1:0] cfg_flow;
  logic [7:0]    cfg_weight;

  stfq_ranker #(.FLOWS(NF), .BANK_SIZE(BS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .in_flow(in_flow), .in_len(in_len),
    .push(push), .push_rank(push_rank), .push_value(push_value), .push_flow(push_flow),
    .deq_valid(deq_valid), .deq_rank(deq_rank), .deq_flow(deq_flow),
    .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_weight(cfg_weight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   rank;
    logic [31:0]   value;
    logic [NF-1:0] flow;
    int            cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] f_m [NF];
  logic [31:0] w_m [NF];
  logic [31:0] v_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NF-1:0] fl(input int n);
    logic [NF-1:0] one;
    one = NF'(1);
    return one << n;
  endfunction

  function automatic int fidx(input logic [NF-1:0] f);
    int r;
    r = 0;
    for (int i = 0; i < NF; i++) if (f[i]) r = i;
    return r;
  endfunction

  task automatic model_push(input logic [NF-1:0] f, input logic [15:0] len, input logic [31:0] val);
    exp_t        e;
    int          k;
    logic [31:0] st;
    logic [63:0] sum;
    k   = fidx(f);
    st  = (v_m > f_m[k]) ? v_m : f_m[k];
    sum = 64'(st) + 64'(len) * 64'(w_m[k]);
    f_m[k] = (sum > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
    e.rank  = st;
    e.value = val;
    e.flow  = f;
    e.cyc   = cyc + 2;
    sb.push_back(e);
  endtask

  // Scoreboard: every push must match the oldest expected packet, in the expected cycle.
  always @(negedge clk) begin
    if (push) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_push observed=%h expected=none", push_rank);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("push_rank", 64'(push_rank), 64'(e.rank));
        chk("push_value", 64'(push_value), 64'(e.value));
        chk("push_flow", 64'(push_flow), 64'(e.flow));
        chk("push_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic offer(input logic [NF-1:0] f, input logic [15:0] len, input logic [31:0] val,
                       input logic exp_rdy);
    @(negedge clk);
    deq_valid = 1'b0; cfg_we = 1'b0;
    in_valid = 1'b1; in_flow = f; in_len = len; in_value = val;
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_rdy) model_push(f, len, val);
  endtask

  task automatic deq(input logic [NF-1:0] f, input logic [31:0] rank);
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    deq_valid = 1'b1; deq_flow = f; deq_rank = rank;
    if (rank > v_m) v_m = rank;
  endtask

  task automatic cfg(input logic [NF-1:0] f, input logic [7:0] w);
    @(negedge clk);
    in_valid = 1'b0; deq_valid = 1'b0;
    cfg_we = 1'b1; cfg_flow = f; cfg_weight = w;
`ifdef STFQ_WEIGHT_EN
    w_m[fidx(f)] = (w == 8'd0) ? 32'd1 : 32'(w);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; deq_valid = 1'b0; cfg_we = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < NF; i++) begin
      f_m[i] = 32'd0;
      w_m[i] = 32'd1;
    end
    v_m = 32'd0;
    rst = 1'b0;
    in_valid = 1'b1; in_flow = fl(0); in_len = 16'd100; in_value = 32'hDEAD_0000;
    deq_valid = 1'b0; deq_rank = 32'd0; deq_flow = '0;
    cfg_we = 1'b0; cfg_flow = '0; cfg_weight = 8'd0;

    // Reset held with a valid packet presented
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_push", 64'(push), 64'd0);
    chk("rst_push_rank", 64'(push_rank), 64'd0);
    chk("rst_push_value", 64'(push_value), 64'd0);
    chk("rst_push_flow", 64'(push_flow), 64'd0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    idle(3);
    #1;
    chk("post_rst_push", 64'(push), 64'd0);
    chk("post_rst_rank", 64'(push_rank), 64'd0);

    // Single flow, back-to-back: ranks 0, 100, 200
    offer(fl(0), 16'd100, 32'hA000_0001, 1'b1);
    offer(fl(0), 16'd100, 32'hA000_0002, 1'b1);
    offer(fl(0), 16'd100, 32'hA000_0003, 1'b1);
    idle(3);

    // Two fresh flows with weights 1 and 2, alternating
    cfg(fl(3), 8'd1);
    cfg(fl(4), 8'd2);
    offer(fl(3), 16'd10, 32'hB000_0001, 1'b1);
    offer(fl(4), 16'd10, 32'hB000_0002, 1'b1);
    offer(fl(3), 16'd10, 32'hB000_0003, 1'b1);
    offer(fl(4), 16'd10, 32'hB000_0004, 1'b1);
    idle(3);

    // Virtual time advances to 500, then a smaller departure rank leaves it there
    deq(fl(0), 32'd500);
    offer(fl(2), 16'd10, 32'hC000_0001, 1'b1);
    deq(fl(0), 32'd300);
    offer(fl(5), 16'd10, 32'hC000_0002, 1'b1);
    idle(3);

    // Fill flow 1, hold the extra packet, check other flows stay open
    offer(fl(1), 16'd5, 32'hD000_0001, 1'b1);
    offer(fl(1), 16'd5, 32'hD000_0002, 1'b1);
    offer(fl(1), 16'd5, 32'hD000_0003, 1'b1);
    offer(fl(1), 16'd5, 32'hD000_0004, 1'b0);
    offer(fl(6), 16'd5, 32'hD000_0005, 1'b1);
    offer(fl(1), 16'd5, 32'hD000_0004, 1'b0);
    @(negedge clk);
    deq_valid = 1'b1; deq_flow = fl(1); deq_rank = 32'd0;
    #1;
    chk("full_still_held", 64'(in_ready), 64'd0);
    @(negedge clk);
    deq_valid = 1'b0;
    #1;
    chk("full_released", 64'(in_ready), 64'd1);
    model_push(fl(1), 16'd5, 32'hD000_0004);
    deq(fl(1), 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_flow = fl(1); in_len = 16'd5; in_value = 32'hD000_0006;
    deq_valid = 1'b1; deq_flow = fl(1); deq_rank = 32'd0;
    #1;
    chk("simul_ready", 64'(in_ready), 64'd1);
    model_push(fl(1), 16'd5, 32'hD000_0006);
    offer(fl(1), 16'd5, 32'hD000_0007, 1'b1);
    offer(fl(1), 16'd5, 32'hD000_0008, 1'b0);
    idle(3);

    // Finish-tag saturation
    deq(fl(0), 32'hFFFF_FFF0);
    offer(fl(0), 16'd100, 32'hE000_0001, 1'b1);
    offer(fl(0), 16'd1, 32'hE000_0002, 1'b1);
    idle(3);

    // Non-one-hot flows are never accepted
    offer('0, 16'd10, 32'hF000_0001, 1'b0);
    offer(fl(0) | fl(1), 16'd10, 32'hF000_0002, 1'b0);
    idle(5);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
